// File: rtl/multicycle_control_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_control_pkg
// Shared definitions for the multicycle MIPS control unit (the mips_ctrl_defs
// set): state encodings, opcode constants, ALUOp / ALUSrcB / PCSource
// encodings and the packed control-word struct.
// ---------------------------------------------------------------------------
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_REG      = 2'd0;
  localparam logic [1:0] SRCB_FOUR     = 2'd1;
  localparam logic [1:0] SRCB_SEXT     = 2'd2;
  localparam logic [1:0] SRCB_SEXT_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // Selects parked at their FETCH values, every strobe low. Used while the
  // controller is held in reset.
  function automatic ctrl_t fetch_selects_idle();
    ctrl_t c;
    c           = '0;
    c.alu_src_b = SRCB_FOUR;
    c.alu_op    = ALUOP_ADD;
    c.pc_source = PCSRC_ALU;
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Bundle between the control FSM and the multicycle datapath.
//   master : controller side (reads Opcode/Zero, drives strobes and selects)
//   slave  : datapath side
// Parameters: OPW opcode width, STW state/debug width.
// ---------------------------------------------------------------------------
interface multicycle_control_if #(
  parameter int OPW = 6,
  parameter int STW = 4
);
  logic [OPW-1:0] Opcode;
  logic           Zero;
  logic           PCEn;
  logic           IorD;
  logic           MemRead;
  logic           MemWrite;
  logic           IRWrite;
  logic           MemtoReg;
  logic           RegDst;
  logic           RegWrite;
  logic           ALUSrcA;
  logic [1:0]     ALUSrcB;
  logic [1:0]     ALUOp;
  logic [1:0]     PCSource;
  logic           IllegalOp;
  logic [STW-1:0] State;

  modport master (
    input  Opcode, Zero,
    output PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp, State
  );

  modport slave (
    output Opcode, Zero,
    input  PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp, State
  );
endinterface

// File: rtl/multicycle_control_output_decode.sv
// ---------------------------------------------------------------------------
// multicycle_control_output_decode (mc_output_decode)
// Purely combinational State -> control-word table of the Moore controller.
// Ports:
//   state : current FSM state
//   ctrl  : decoded selects/strobes (PCWrite/PCWriteCond still unmerged)
// Optional feature macro: MULTICYCLE_ADDI_EN (adds ADDIEX/ADDIWB rows).
// Unknown states, and ADDIEX/ADDIWB without the feature, decode to all zero.
// ---------------------------------------------------------------------------
module multicycle_control_output_decode
  import multicycle_control_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.pc_write  = 1'b1;
      end
      ST_DECODE: begin
        // Branch target is precomputed here while the opcode is decoded.
        ctrl.alu_src_b = SRCB_SEXT_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SEXT;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
`ifdef MULTICYCLE_ADDI_EN
      ST_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SEXT;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore FSM sequencing the multicycle MIPS datapath (PC, IR, ALU, register
// file, memory). Sole owner of the PC and memory write enables.
// Ports:
//   Clk    : rising-edge clock
//   Reset  : synchronous, active-high; forces FETCH from any state
//   bus    : multicycle_control_if.master
//            in  Opcode (IR[31:26]), Zero (ALU zero flag)
//            out PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
//                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp, State
// Parameters: OPW opcode width, STW state debug width.
// Optional feature macro: MULTICYCLE_ADDI_EN (addi via ADDIEX/ADDIWB).
// ---------------------------------------------------------------------------
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input logic                  Clk,
  input logic                  Reset,
  multicycle_control_if.master bus
);

  state_t         state_reg;
  state_t         state_next;
  logic           illegal_op;
  logic [OPW-1:0] opcode;
  ctrl_t          decoded;
  ctrl_t          ctrl;

  assign opcode = bus.Opcode;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= ST_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Opcode is only looked at in DECODE and MEMADR; the IR holds it there.
  always_comb begin
    state_next = ST_FETCH;
    illegal_op = 1'b0;
    case (state_reg)
      ST_FETCH:  state_next = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = ST_MEMADR;
          OP_RTYPE:     state_next = ST_EXEC;
          OP_BEQ:       state_next = ST_BRANCH;
          OP_J:         state_next = ST_JUMP;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:      state_next = ST_ADDIEX;
`endif
          default: begin
            state_next = ST_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      ST_MEMADR: begin
        if (opcode == OP_LW) begin
          state_next = ST_MEMRD;
        end else if (opcode == OP_SW) begin
          state_next = ST_MEMWR;
        end else begin
          state_next = ST_FETCH;
        end
      end
      ST_MEMRD:  state_next = ST_MEMWB;
      ST_EXEC:   state_next = ST_ALUWB;
`ifdef MULTICYCLE_ADDI_EN
      ST_ADDIEX: state_next = ST_ADDIWB;
`endif
      // Terminal states and any unused encoding all return to FETCH.
      default:   state_next = ST_FETCH;
    endcase
  end

  multicycle_control_output_decode u_decode (
    .state (state_reg),
    .ctrl  (decoded)
  );

  // Reset overrides the table combinationally so no strobe fires on the
  // cycle reset is raised, even mid-instruction.
  always_comb begin
    if (Reset) begin
      ctrl = fetch_selects_idle();
    end else begin
      ctrl = decoded;
    end
  end

  assign bus.PCEn      = ctrl.pc_write | (ctrl.pc_write_cond & bus.Zero);
  assign bus.IorD      = ctrl.iord;
  assign bus.MemRead   = ctrl.mem_read;
  assign bus.MemWrite  = ctrl.mem_write;
  assign bus.IRWrite   = ctrl.ir_write;
  assign bus.MemtoReg  = ctrl.mem_to_reg;
  assign bus.RegDst    = ctrl.reg_dst;
  assign bus.RegWrite  = ctrl.reg_write;
  assign bus.ALUSrcA   = ctrl.alu_src_a;
  assign bus.ALUSrcB   = ctrl.alu_src_b;
  assign bus.ALUOp     = ctrl.alu_op;
  assign bus.PCSource  = ctrl.pc_source;
  assign bus.IllegalOp = illegal_op & ~Reset;
  assign bus.State     = STW'(state_reg);

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Self-checking bench for multicycle_control: reset checks, a table of
// per-instruction cycle counts / IllegalOp pulses, hand sequences for beq,
// jump, addi and reset during MEMWR, then random instruction streams checked
// cycle by cycle against an instruction-level reference model.
// Honours MULTICYCLE_ADDI_EN for the expected addi behaviour.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

`ifdef MULTICYCLE_ADDI_EN
  localparam bit ADDI_ON = 1'b1;
`else
  localparam bit ADDI_ON = 1'b0;
`endif

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       ill;
  } out_t;

  typedef struct {
    logic [5:0] op;
    int         cycles;
    int         pulses;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset;
  int   tests = 0;
  int   fails = 0;

  always #5 Clk = ~Clk;

  multicycle_control_if bus ();

  multicycle_control dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic out_t observe();
    out_t o;
    o.pcen  = bus.PCEn;
    o.iord  = bus.IorD;
    o.mrd   = bus.MemRead;
    o.mwr   = bus.MemWrite;
    o.irw   = bus.IRWrite;
    o.m2r   = bus.MemtoReg;
    o.rdst  = bus.RegDst;
    o.rw    = bus.RegWrite;
    o.srca  = bus.ALUSrcA;
    o.srcb  = bus.ALUSrcB;
    o.aluop = bus.ALUOp;
    o.pcsrc = bus.PCSource;
    o.ill   = bus.IllegalOp;
    return o;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op == 6'h23) || (op == 6'h2B) || (op == 6'h00) || (op == 6'h04) ||
           (op == 6'h02) || (ADDI_ON && op == 6'h08);
  endfunction

  // FETCH-to-FETCH cycle count of one instruction.
  function automatic int instr_len(input logic [5:0] op);
    if (!is_legal(op)) return 2;
    case (op)
      6'h23:   return 5;
      6'h2B:   return 4;
      6'h00:   return 4;
      6'h08:   return 4;
      default: return 3;
    endcase
  endfunction

  // i-th state visited by an instruction, starting at FETCH.
  function automatic int path_state(input logic [5:0] op, input int i);
    int p[5];
    p = '{0, 1, 0, 0, 0};
    if (is_legal(op)) begin
      case (op)
        6'h23:   p = '{0, 1, 2, 3, 4};
        6'h2B:   p = '{0, 1, 2, 5, 0};
        6'h00:   p = '{0, 1, 6, 7, 0};
        6'h04:   p = '{0, 1, 8, 0, 0};
        6'h02:   p = '{0, 1, 9, 0, 0};
        6'h08:   p = '{0, 1, 10, 11, 0};
        default: p = '{0, 1, 0, 0, 0};
      endcase
    end
    return p[i];
  endfunction

  // Expected controls for a state, straight from the state table.
  function automatic out_t model_out(input int st, input logic [5:0] op,
                                     input logic zero, input logic rst);
    out_t o;
    o = '0;
    if (rst) begin
      o.srcb = 2'd1;
      return o;
    end
    case (st)
      0:  begin o.mrd = 1; o.irw = 1; o.srcb = 2'd1; o.pcen = 1; end
      1:  begin o.srcb = 2'd3; o.ill = !is_legal(op); end
      2:  begin o.srca = 1; o.srcb = 2'd2; end
      3:  begin o.mrd = 1; o.iord = 1; end
      4:  begin o.rw = 1; o.m2r = 1; end
      5:  begin o.mwr = 1; o.iord = 1; end
      6:  begin o.srca = 1; o.aluop = 2'd2; end
      7:  begin o.rw = 1; o.rdst = 1; end
      8:  begin o.srca = 1; o.aluop = 2'd1; o.pcsrc = 2'd1; o.pcen = zero; end
      9:  begin o.pcsrc = 2'd2; o.pcen = 1; end
      10: if (ADDI_ON) begin o.srca = 1; o.srcb = 2'd2; end
      11: if (ADDI_ON) begin o.rw = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Called just after a rising edge with the DUT in FETCH; zmode 0/1 fixes
  // Zero, 2 randomizes it every cycle.
  task automatic run_instr(input logic [5:0] op, input int zmode);
    int n;
    int st;
    n = instr_len(op);
    bus.Opcode = op;
    for (int i = 0; i < n; i++) begin
      if (zmode == 2) bus.Zero = 1'($urandom_range(0, 1));
      else            bus.Zero = zmode[0];
      @(negedge Clk);
      st = path_state(op, i);
      check($sformatf("state op=%02h step=%0d", op, i), 32'(bus.State), 32'(st));
      check($sformatf("outputs op=%02h step=%0d", op, i), 32'(observe()),
            32'(model_out(st, op, bus.Zero, 1'b0)));
      @(posedge Clk);
      #1;
    end
    $display("[TB] instr op=0x%02h zero_mode=%0d cycles=%0d", op, zmode, n);
  endtask

  initial begin
    vec_t vecs[8];
    logic [5:0] pick[7];
    logic [5:0] op;
    int c;
    int pulses;

    vecs[0] = '{6'h23, 5, 0};
    vecs[1] = '{6'h2B, 4, 0};
    vecs[2] = '{6'h00, 4, 0};
    vecs[3] = '{6'h04, 3, 0};
    vecs[4] = '{6'h02, 3, 0};
    vecs[5] = '{6'h3F, 2, 1};
    vecs[6] = '{6'h01, 2, 1};
    vecs[7] = ADDI_ON ? '{6'h08, 4, 0} : '{6'h08, 2, 1};
    pick    = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08, 6'h3F};

    // Reset held for two cycles.
    Reset      = 1'b1;
    bus.Opcode = 6'h00;
    bus.Zero   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      check($sformatf("reset state %0d", i), 32'(bus.State), 32'd0);
      check($sformatf("reset outputs %0d", i), 32'(observe()),
            32'(model_out(0, 6'h00, 1'b1, 1'b1)));
    end
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    check("first fetch outputs", 32'(observe()), 32'(model_out(0, 6'h00, 1'b1, 1'b0)));
    @(posedge Clk);
    #1;
    // One cycle of DECODE on opcode 0 (R-type) was entered; finish it.
    for (int i = 0; i < 20 && bus.State != 4'd0; i++) begin
      @(posedge Clk);
      #1;
    end
    check("back to fetch after first instr", 32'(bus.State), 32'd0);

    // Table: cycle count and IllegalOp pulse count per opcode.
    foreach (vecs[k]) begin
      bus.Opcode = vecs[k].op;
      bus.Zero   = 1'b0;
      c      = 0;
      pulses = 0;
      do begin
        @(negedge Clk);
        pulses += int'(bus.IllegalOp);
        @(posedge Clk);
        #1;
        c++;
      end while (bus.State != 4'd0 && c < 20);
      check($sformatf("cycles op=%02h", vecs[k].op), 32'(c), 32'(vecs[k].cycles));
      check($sformatf("illegal pulses op=%02h", vecs[k].op), 32'(pulses), 32'(vecs[k].pulses));
      $display("[TB] table op=0x%02h cycles=%0d pulses=%0d", vecs[k].op, c, pulses);
    end

    // Hand sequences: lw, beq taken/not taken, jump, illegal, addi.
    run_instr(6'h23, 0);
    run_instr(6'h04, 1);
    run_instr(6'h04, 0);
    run_instr(6'h02, 0);
    run_instr(6'h3F, 1);
    run_instr(6'h08, 0);

    // Reset raised while in MEMWR.
    bus.Opcode = 6'h2B;
    bus.Zero   = 1'b0;
    repeat (3) begin
      @(posedge Clk);
      #1;
    end
    Reset = 1'b1;
    @(negedge Clk);
    check("memwr reset state", 32'(bus.State), 32'd5);
    check("memwr reset MemWrite", 32'(bus.MemWrite), 32'd0);
    check("memwr reset outputs", 32'(observe()), 32'(model_out(5, 6'h2B, 1'b0, 1'b1)));
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    check("after memwr reset state", 32'(bus.State), 32'd0);
    check("after memwr reset outputs", 32'(observe()), 32'(model_out(0, 6'h2B, 1'b0, 1'b0)));
    @(posedge Clk);
    #1;
    // Finish the sw that restarted from FETCH.
    for (int i = 1; i < instr_len(6'h2B); i++) begin
      @(posedge Clk);
      #1;
    end

    // Random instruction stream with random Zero.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
      else                           op = pick[$urandom_range(0, 6)];
      run_instr(op, 2);
    end
    @(negedge Clk);
    check("final state", 32'(bus.State), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
